// File: rtl/cache_pkg.sv
// Shared types and defaults for the single-set cache controller.
package cache_pkg;

  localparam int DEF_NUM_WAYS  = 8;
  localparam int DEF_TAG_WIDTH = 20;
  localparam int CNT_WIDTH     = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    EVICT  = 3'd2,
    UPDATE = 3'd3,
    RESP   = 3'd4
  } state_t;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/way_priority_select.sv
// One-hot isolation of the lowest set bit of a way vector.
module way_priority_select #(
  parameter int NUM_WAYS = 8
) (
  input  logic [NUM_WAYS-1:0] i_req,
  output logic [NUM_WAYS-1:0] o_grant
);

  // x & -x keeps only the least-significant set bit; zero in gives zero out.
  assign o_grant = i_req & ((~i_req) + {{(NUM_WAYS-1){1'b0}}, 1'b1});

endmodule

// File: rtl/cache_set_controller.sv
// One N-way cache set: tag lookup, fill into a free or policy-chosen victim
// way, eviction-policy notifications, and a held response handshake.
module cache_set_controller
  import cache_pkg::*;
#(
  parameter int NUM_WAYS  = DEF_NUM_WAYS,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [TAG_WIDTH-1:0] req_tag,
  output logic                 req_ready,
  input  logic                 flush,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 resp_hit,
  output logic [NUM_WAYS-1:0]  resp_way,
  output logic [NUM_WAYS-1:0]  hitWay,
  output logic [NUM_WAYS-1:0]  allocateWay,
  input  logic [NUM_WAYS-1:0]  evictionTarget,
  input  logic                 evictionReady,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
);

  state_t               r_state;
  logic [TAG_WIDTH-1:0] r_tag;
  logic [TAG_WIDTH-1:0] r_tags [NUM_WAYS];
  logic [NUM_WAYS-1:0]  r_valid;
  logic [NUM_WAYS-1:0]  r_sel;
  logic                 r_hit;
  logic                 r_resp_valid;
  logic                 r_resp_hit;
  logic [NUM_WAYS-1:0]  r_resp_way;
  logic [NUM_WAYS-1:0]  r_hit_way;
  logic [NUM_WAYS-1:0]  r_alloc_way;
  logic [15:0]          r_hit_count;
  logic [15:0]          r_miss_count;

  logic [NUM_WAYS-1:0]  w_match;
  logic [NUM_WAYS-1:0]  w_match_sel;
  logic [NUM_WAYS-1:0]  w_free_sel;
  logic [NUM_WAYS-1:0]  w_victim_sel;
  logic [15:0]          w_hit_count_nxt;
  logic [15:0]          w_miss_count_nxt;

  // Parallel tag compare of the captured request against every valid way.
  always_comb begin
    w_match = {NUM_WAYS{1'b0}};
    for (int i = 0; i < NUM_WAYS; i++) begin
      w_match[i] = r_valid[i] && (r_tags[i] == r_tag);
    end
  end

  way_priority_select #(.NUM_WAYS(NUM_WAYS)) u_match_sel (
    .i_req  (w_match),
    .o_grant(w_match_sel)
  );

  way_priority_select #(.NUM_WAYS(NUM_WAYS)) u_free_sel (
    .i_req  (~r_valid),
    .o_grant(w_free_sel)
  );

  way_priority_select #(.NUM_WAYS(NUM_WAYS)) u_victim_sel (
    .i_req  (evictionTarget),
    .o_grant(w_victim_sel)
  );

  // Lookup/fill/response sequencer; also owns tag and valid storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_tag        <= {TAG_WIDTH{1'b0}};
      r_valid      <= {NUM_WAYS{1'b0}};
      r_sel        <= {NUM_WAYS{1'b0}};
      r_hit        <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= {NUM_WAYS{1'b0}};
      r_hit_way    <= {NUM_WAYS{1'b0}};
      r_alloc_way  <= {NUM_WAYS{1'b0}};
      for (int i = 0; i < NUM_WAYS; i++) begin
        r_tags[i] <= {TAG_WIDTH{1'b0}};
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_valid <= {NUM_WAYS{1'b0}};
          end else if (req_valid) begin
            r_tag   <= req_tag;
            r_state <= LOOKUP;
          end
        end
        LOOKUP: begin
          r_hit <= |w_match;
          if (|w_match) begin
            r_sel     <= w_match_sel;
            r_hit_way <= w_match_sel;
            r_state   <= UPDATE;
          end else if (!(&r_valid)) begin
            r_sel       <= w_free_sel;
            r_alloc_way <= w_free_sel;
            r_state     <= UPDATE;
          end else begin
            r_state <= EVICT;
          end
        end
        EVICT: begin
          // A ready policy with an empty target is not a usable answer.
          if (evictionReady && (|evictionTarget)) begin
            r_sel       <= w_victim_sel;
            r_alloc_way <= w_victim_sel;
            r_state     <= UPDATE;
          end
        end
        UPDATE: begin
          r_hit_way   <= {NUM_WAYS{1'b0}};
          r_alloc_way <= {NUM_WAYS{1'b0}};
          if (!r_hit) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
              if (r_sel[i]) begin
                r_tags[i]  <= r_tag;
                r_valid[i] <= 1'b1;
              end
            end
          end
          r_resp_valid <= 1'b1;
          r_resp_hit   <= r_hit;
          r_resp_way   <= r_sel;
          r_state      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_way   <= {NUM_WAYS{1'b0}};
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Saturating statistics, advanced as UPDATE retires.
  always_comb begin
    w_hit_count_nxt  = r_hit_count;
    w_miss_count_nxt = r_miss_count;
    if (r_state == UPDATE) begin
      if (r_hit) begin
        w_hit_count_nxt = sat_inc(r_hit_count);
      end else begin
        w_miss_count_nxt = sat_inc(r_miss_count);
      end
    end else begin
      w_hit_count_nxt  = r_hit_count;
      w_miss_count_nxt = r_miss_count;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= 16'h0000;
      r_miss_count <= 16'h0000;
    end else begin
      r_hit_count  <= w_hit_count_nxt;
      r_miss_count <= w_miss_count_nxt;
    end
  end

  assign req_ready   = rst_n && (r_state == IDLE) && !flush;
  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign resp_way    = r_resp_way;
  assign hitWay      = r_hit_way;
  assign allocateWay = r_alloc_way;
  assign hit_count   = r_hit_count;
  assign miss_count  = r_miss_count;

endmodule

// File: tb/tb_cache_set_controller.sv
// Scoreboard bench for cache_set_controller with NUM_WAYS=4, TAG_WIDTH=8.
module tb_cache_set_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [7:0] req_tag = 8'h00;
  logic       req_ready;
  logic       flush = 1'b0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic       resp_hit;
  logic [3:0] resp_way;
  logic [3:0] hitWay;
  logic [3:0] allocateWay;
  logic [3:0] evictionTarget = 4'b0000;
  logic       evictionReady = 1'b0;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int cmp  = 0;
  int errs = 0;
  logic [15:0] exp_hits = 16'h0000;
  logic [15:0] exp_miss = 16'h0000;

  typedef struct {
    logic [7:0] tag;
    int         ev_wait;
    logic       ev_zero;
    logic [3:0] ev_tgt;
    int         hold;
    logic       hit;
    logic [3:0] way;
    int         lat;
  } txn_t;

  typedef struct {
    int         lat;
    logic       hit;
    logic [3:0] way;
    logic [3:0] hp;
    logic [3:0] ap;
    int         pulses;
    bit         both;
    bit         stable;
    bit         rdy_low;
    logic       after_valid;
    logic [3:0] after_way;
    logic       after_ready;
  } obs_t;

  txn_t expq[$];

  cache_set_controller #(.NUM_WAYS(4), .TAG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_tag(req_tag), .req_ready(req_ready),
    .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit), .resp_way(resp_way),
    .hitWay(hitWay), .allocateWay(allocateWay),
    .evictionTarget(evictionTarget), .evictionReady(evictionReady),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic txn_t mk(input logic [7:0] tag, input int ev_wait, input logic ev_zero,
                              input logic [3:0] ev_tgt, input int hold,
                              input logic hit, input logic [3:0] way, input int lat);
    txn_t t;
    t.tag = tag; t.ev_wait = ev_wait; t.ev_zero = ev_zero; t.ev_tgt = ev_tgt;
    t.hold = hold; t.hit = hit; t.way = way; t.lat = lat;
    return t;
  endfunction

  function automatic void model_count(input logic hit);
    if (hit) exp_hits = (exp_hits == 16'hFFFF) ? exp_hits : exp_hits + 16'd1;
    else     exp_miss = (exp_miss == 16'hFFFF) ? exp_miss : exp_miss + 16'd1;
  endfunction

  // Drives one request and records what the DUT shows; latency counted in
  // negedges after the accepting posedge, 0 meaning no response in budget.
  task automatic run_txn(input txn_t t, output obs_t o);
    o.lat = 0; o.hit = 1'b0; o.way = 4'b0; o.hp = 4'b0; o.ap = 4'b0; o.pulses = 0;
    o.both = 0; o.stable = 1; o.rdy_low = 1; o.after_valid = 1'b0; o.after_way = 4'b0;
    o.after_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_tag = t.tag; resp_ready = (t.hold == 0);
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (hitWay != 4'b0) begin o.hp |= hitWay; o.pulses++; end
      if (allocateWay != 4'b0) begin o.ap |= allocateWay; o.pulses++; end
      if (hitWay != 4'b0 && allocateWay != 4'b0) o.both = 1;
      if (resp_valid === 1'b1) begin
        o.lat = n; o.hit = resp_hit; o.way = resp_way;
        break;
      end
      if (t.ev_tgt != 4'b0 && n > t.ev_wait) begin
        evictionReady = 1'b1; evictionTarget = t.ev_tgt;
      end else begin
        evictionReady = t.ev_zero; evictionTarget = 4'b0;
      end
    end
    evictionReady = 1'b0; evictionTarget = 4'b0;
    for (int k = 0; k < t.hold; k++) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_way !== o.way || resp_hit !== o.hit) o.stable = 0;
      if (req_ready !== 1'b0) o.rdy_low = 0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    o.after_valid = resp_valid; o.after_way = resp_way; o.after_ready = req_ready;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cmp++;
    if ({resp_valid, resp_hit, resp_way, hitWay, allocateWay} !== 11'b0 ||
        hit_count !== 16'h0 || miss_count !== 16'h0) begin
      errs++;
      $display("FAIL reset_outputs got v=%b h=%b w=%b hw=%b aw=%b hc=%h mc=%h exp all zero",
               resp_valid, resp_hit, resp_way, hitWay, allocateWay, hit_count, miss_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    cmp++;
    if (req_ready !== 1'b1) begin
      errs++; $display("FAIL reset_ready got %b exp 1", req_ready);
    end
    exp_hits = 16'h0; exp_miss = 16'h0;
  endtask

  task automatic test_miss_hit();
    txn_t e; obs_t o; txn_t s[$];
    s.push_back(mk(8'h11, 0, 1'b0, 4'b0, 0, 1'b0, 4'b0001, 3));
    s.push_back(mk(8'h11, 0, 1'b0, 4'b0, 0, 1'b1, 4'b0001, 3));
    foreach (s[i]) begin
      expq.push_back(s[i]);
      run_txn(s[i], o);
      e = expq.pop_front();
      model_count(e.hit);
      cmp++; if (o.lat != e.lat) begin errs++; $display("FAIL mh_latency tag=%h got %0d exp %0d", e.tag, o.lat, e.lat); end
      cmp++; if (o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL mh_resp tag=%h got hit=%b way=%b exp hit=%b way=%b", e.tag, o.hit, o.way, e.hit, e.way); end
      cmp++; if (o.hp !== (e.hit ? e.way : 4'b0) || o.ap !== (e.hit ? 4'b0 : e.way) || o.pulses != 1 || o.both) begin errs++; $display("FAIL mh_notify tag=%h got hw=%b aw=%b cycles=%0d exp way=%b hit=%b one cycle", e.tag, o.hp, o.ap, o.pulses, e.way, e.hit); end
      cmp++; if (o.after_valid !== 1'b0 || o.after_way !== 4'b0 || o.after_ready !== 1'b1) begin errs++; $display("FAIL mh_release got v=%b w=%b rdy=%b exp 0 0000 1", o.after_valid, o.after_way, o.after_ready); end
      cmp++; if (hit_count !== exp_hits || miss_count !== exp_miss) begin errs++; $display("FAIL mh_counts got hc=%h mc=%h exp hc=%h mc=%h", hit_count, miss_count, exp_hits, exp_miss); end
    end
  endtask

  task automatic test_fill_evict();
    txn_t e; obs_t o; txn_t s[$];
    s.push_back(mk(8'h22, 0, 1'b0, 4'b0,    0, 1'b0, 4'b0010, 3));
    s.push_back(mk(8'h33, 0, 1'b0, 4'b0,    0, 1'b0, 4'b0100, 3));
    s.push_back(mk(8'h44, 0, 1'b0, 4'b0,    0, 1'b0, 4'b1000, 3));
    s.push_back(mk(8'h55, 6, 1'b0, 4'b0110, 0, 1'b0, 4'b0010, 9));
    s.push_back(mk(8'h22, 4, 1'b1, 4'b1000, 0, 1'b0, 4'b1000, 7));
    s.push_back(mk(8'h55, 0, 1'b0, 4'b0,    0, 1'b1, 4'b0010, 3));
    s.push_back(mk(8'h33, 0, 1'b0, 4'b0,    0, 1'b1, 4'b0100, 3));
    foreach (s[i]) begin
      expq.push_back(s[i]);
      run_txn(s[i], o);
      e = expq.pop_front();
      model_count(e.hit);
      cmp++; if (o.lat != e.lat) begin errs++; $display("FAIL ev_latency tag=%h got %0d exp %0d", e.tag, o.lat, e.lat); end
      cmp++; if (o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL ev_resp tag=%h got hit=%b way=%b exp hit=%b way=%b", e.tag, o.hit, o.way, e.hit, e.way); end
      cmp++; if (o.hp !== (e.hit ? e.way : 4'b0) || o.ap !== (e.hit ? 4'b0 : e.way) || o.pulses != 1 || o.both) begin errs++; $display("FAIL ev_notify tag=%h got hw=%b aw=%b cycles=%0d exp way=%b hit=%b one cycle", e.tag, o.hp, o.ap, o.pulses, e.way, e.hit); end
      cmp++; if (hit_count !== exp_hits || miss_count !== exp_miss) begin errs++; $display("FAIL ev_counts got hc=%h mc=%h exp hc=%h mc=%h", hit_count, miss_count, exp_hits, exp_miss); end
    end
  endtask

  task automatic test_flush();
    txn_t e; obs_t o; txn_t s[$];
    bit quiet;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_tag = 8'h77;
    #1;
    cmp++; if (req_ready !== 1'b0) begin errs++; $display("FAIL flush_ready got %b exp 0", req_ready); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    quiet = 1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || hitWay !== 4'b0 || allocateWay !== 4'b0 || req_ready !== 1'b1) quiet = 0;
    end
    cmp++; if (!quiet || miss_count !== exp_miss) begin errs++; $display("FAIL flush_blocks got quiet=%0d mc=%h exp quiet=1 mc=%h", quiet, miss_count, exp_miss); end
    s.push_back(mk(8'h11, 0, 1'b0, 4'b0, 0, 1'b0, 4'b0001, 3));
    s.push_back(mk(8'h22, 0, 1'b0, 4'b0, 0, 1'b0, 4'b0010, 3));
    foreach (s[i]) begin
      expq.push_back(s[i]);
      run_txn(s[i], o);
      e = expq.pop_front();
      model_count(e.hit);
      cmp++; if (o.lat != e.lat || o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL fl_resp tag=%h got lat=%0d hit=%b way=%b exp lat=%0d hit=%b way=%b", e.tag, o.lat, o.hit, o.way, e.lat, e.hit, e.way); end
      cmp++; if (o.ap !== e.way || o.hp !== 4'b0 || o.pulses != 1) begin errs++; $display("FAIL fl_notify tag=%h got hw=%b aw=%b exp aw=%b", e.tag, o.hp, o.ap, e.way); end
    end
  endtask

  task automatic test_resp_hold();
    txn_t e; obs_t o;
    expq.push_back(mk(8'h11, 0, 1'b0, 4'b0, 4, 1'b1, 4'b0001, 3));
    run_txn(expq[0], o);
    e = expq.pop_front();
    model_count(e.hit);
    cmp++; if (o.lat != e.lat || o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL hold_resp got lat=%0d hit=%b way=%b exp lat=%0d hit=%b way=%b", o.lat, o.hit, o.way, e.lat, e.hit, e.way); end
    cmp++; if (!o.stable || !o.rdy_low) begin errs++; $display("FAIL hold_stable got stable=%0d ready_low=%0d exp 1 1", o.stable, o.rdy_low); end
    cmp++; if (o.after_valid !== 1'b0 || o.after_ready !== 1'b1) begin errs++; $display("FAIL hold_release got v=%b rdy=%b exp 0 1", o.after_valid, o.after_ready); end
  endtask

  task automatic test_reset_mid_evict();
    txn_t e; obs_t o; txn_t s[$];
    bit quiet;
    s.push_back(mk(8'h33, 0, 1'b0, 4'b0, 0, 1'b0, 4'b0100, 3));
    s.push_back(mk(8'h44, 0, 1'b0, 4'b0, 0, 1'b0, 4'b1000, 3));
    foreach (s[i]) begin
      expq.push_back(s[i]);
      run_txn(s[i], o);
      e = expq.pop_front();
      model_count(e.hit);
      cmp++; if (o.lat != e.lat || o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL re_fill tag=%h got lat=%0d hit=%b way=%b exp lat=%0d hit=%b way=%b", e.tag, o.lat, o.hit, o.way, e.lat, e.hit, e.way); end
    end
    @(negedge clk);
    req_valid = 1'b1; req_tag = 8'h66;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    evictionReady = 1'b1; evictionTarget = 4'b0001; rst_n = 1'b0;
    #1;
    cmp++;
    if ({resp_valid, resp_hit, resp_way, hitWay, allocateWay, req_ready} !== 12'b0 ||
        hit_count !== 16'h0 || miss_count !== 16'h0) begin
      errs++;
      $display("FAIL mid_reset_outputs got v=%b h=%b w=%b hw=%b aw=%b rdy=%b hc=%h mc=%h exp all zero",
               resp_valid, resp_hit, resp_way, hitWay, allocateWay, req_ready, hit_count, miss_count);
    end
    quiet = 1;
    repeat (2) begin @(negedge clk); if (allocateWay !== 4'b0 || resp_valid !== 1'b0) quiet = 0; end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); if (allocateWay !== 4'b0 || hitWay !== 4'b0 || resp_valid !== 1'b0) quiet = 0; end
    evictionReady = 1'b0; evictionTarget = 4'b0;
    cmp++; if (!quiet || req_ready !== 1'b1) begin errs++; $display("FAIL mid_reset_abort got quiet=%0d rdy=%b exp 1 1", quiet, req_ready); end
    exp_hits = 16'h0; exp_miss = 16'h0;
    expq.push_back(mk(8'h11, 0, 1'b0, 4'b0, 0, 1'b0, 4'b0001, 3));
    run_txn(expq[0], o);
    e = expq.pop_front();
    model_count(e.hit);
    cmp++; if (o.lat != e.lat || o.hit !== e.hit || o.way !== e.way || o.ap !== e.way) begin errs++; $display("FAIL post_reset_miss got lat=%0d hit=%b way=%b aw=%b exp lat=%0d hit=%b way=%b", o.lat, o.hit, o.way, o.ap, e.lat, e.hit, e.way); end
    cmp++; if (hit_count !== exp_hits || miss_count !== exp_miss) begin errs++; $display("FAIL post_reset_counts got hc=%h mc=%h exp hc=%h mc=%h", hit_count, miss_count, exp_hits, exp_miss); end
  endtask

  task automatic test_saturation();
    txn_t e; obs_t o;
    @(negedge clk);
    force dut.r_hit_count = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.r_hit_count;
    exp_hits = 16'hFFFE;
    @(negedge clk);
    cmp++; if (hit_count !== exp_hits) begin errs++; $display("FAIL sat_preload got %h exp %h", hit_count, exp_hits); end
    for (int i = 0; i < 2; i++) begin
      expq.push_back(mk(8'h11, 0, 1'b0, 4'b0, 0, 1'b1, 4'b0001, 3));
      run_txn(expq[0], o);
      e = expq.pop_front();
      model_count(e.hit);
      cmp++; if (o.hit !== e.hit || o.way !== e.way) begin errs++; $display("FAIL sat_resp got hit=%b way=%b exp hit=%b way=%b", o.hit, o.way, e.hit, e.way); end
      cmp++; if (hit_count !== exp_hits || miss_count !== exp_miss) begin errs++; $display("FAIL sat_counts got hc=%h mc=%h exp hc=%h mc=%h", hit_count, miss_count, exp_hits, exp_miss); end
    end
  endtask

  initial begin
    test_reset();
    test_miss_hit();
    test_fill_evict();
    test_flush();
    test_resp_hold();
    test_reset_mid_evict();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end

endmodule
